// File: rtl/ram_bank.sv
// Single-port-per-direction RAM bank with a built-in clear engine that sweeps
// CLEAR_VALUE through every word after reset or on request.
module ram_bank #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic                  clear_request,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    vld_q, vld_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = write_address;
    mem_wd  = input_data;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = CLEAR_VALUE;
        cnt_d  = cnt_q + 1'b1;  // wraps to 0 after the last word
        if (clear_request)
          cnt_d = '0;
        else if (&cnt_q)
          state_d = READY;
      end
      default: begin
        mem_we = write_enable;
        if (read_enable) begin
          vld_d  = 1'b1;
          // write-first bypass on a same-address collision
          dout_d = (write_enable && (write_address == read_address)) ?
                   input_data : mem[read_address];
        end
        if (clear_request) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // reset forces the visible outputs immediately, not just after the edge
  assign busy         = reset || (state_q == CLEAR);
  assign output_data  = reset ? '0 : dout_q;
  assign output_valid = vld_q && !reset;

endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: default build driven against a reference
// model, plus a small directed run on a 16x16 build with a non-zero clear value.
module tb_ram_bank;
  localparam int DW = 8, AW = 6, DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, we, re, clr;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd, dout;
  logic vld, busy;

  logic b_reset, b_we, b_re, b_clr;
  logic [3:0] b_wa, b_ra;
  logic [15:0] b_wd, b_dout;
  logic b_vld, b_busy;

  ram_bank dut (
    .clk(clk), .reset(reset), .write_enable(we), .write_address(wa),
    .input_data(wd), .read_enable(re), .read_address(ra),
    .clear_request(clr), .output_data(dout), .output_valid(vld), .busy(busy)
  );

  ram_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(16'hBEEF)) dut_sw (
    .clk(clk), .reset(b_reset), .write_enable(b_we), .write_address(b_wa),
    .input_data(b_wd), .read_enable(b_re), .read_address(b_ra),
    .clear_request(b_clr), .output_data(b_dout), .output_valid(b_vld), .busy(b_busy)
  );

  int ntot = 0, nbad = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp2_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_dout;
  int  rem;
  logic prev_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle on the default DUT: drive, check at negedge, advance model
  task automatic step(input logic r, input logic w, input int a_w, input int d,
                      input logic rd, input int a_r, input logic c);
    logic acc_rd;
    logic [DW-1:0] e;
    reset = r; we = w; wa = a_w[AW-1:0]; wd = d[DW-1:0];
    re = rd; ra = a_r[AW-1:0]; clr = c;
    if (r) exp_q.delete();
    acc_rd = !r && (rem == 0) && rd;
    if (acc_rd) exp_q.push_back((w && wa == ra) ? wd : model[ra]);
    @(negedge clk);
    chk("busy", busy, r || (rem > 0));
    chk("vld", vld, prev_rd && !r);
    if (vld && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_data", dout, e);
      last_dout = e;
    end else if (r) begin
      chk("rst_dout", dout, 0);
      last_dout = '0;
    end else begin
      chk("hold", dout, last_dout);
    end
    if (r) begin
      rem = DEPTH;
      foreach (model[i]) model[i] = '0;
    end else if (rem > 0) begin
      rem = c ? DEPTH : rem - 1;
    end else begin
      if (w) model[wa] = wd;
      if (c) begin
        rem = DEPTH;
        foreach (model[i]) model[i] = '0;
      end
    end
    prev_rd = acc_rd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, 0, 0, 1, a, 0);
  endtask

  task automatic b_cycle_chk;
    @(negedge clk);
    if (b_vld && exp2_q.size() > 0) chk("sw_rd", b_dout, exp2_q.pop_front());
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; we = 0; re = 0; clr = 0; wa = 0; ra = 0; wd = 0;
    b_reset = 1; b_we = 0; b_re = 0; b_clr = 0; b_wa = 0; b_ra = 0; b_wd = 0;
    rem = DEPTH; prev_rd = 0; last_dout = '0;
    foreach (model[i]) model[i] = '0;
    @(posedge clk); #1;

    step(1, 1, 2, 8'h99, 1, 2, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 7, 8'hAA, 1, 7, 0);  // ignored while clearing
    rd(34);
    step(0, 1, 3, 8'h0A, 0, 0, 0);
    rd(3);
    rd(63);
    step(0, 1, 17, 8'h5C, 1, 17, 0);
    step(0, 1, 20, 8'h77, 1, 3, 0);
    rd(3); rd(17); rd(20); rd(34); rd(7);
    idle(2);

    step(0, 1, 5, 8'hFF, 0, 0, 0);
    step(0, 1, 9, 8'h33, 1, 5, 1);        // user access in the clear_request cycle is accepted
    step(0, 1, 6, 8'h11, 1, 6, 0);
    idle(DEPTH - 1);
    rd(5); rd(6); rd(9);

    step(0, 1, 40, 8'h44, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(10);
    step(0, 0, 0, 0, 0, 0, 1);            // restart mid-clear
    idle(DEPTH);
    rd(40); rd(0);

    step(0, 0, 0, 0, 0, 0, 1);
    idle(20);
    step(1, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, i, 0);
    rd(1);

    for (int i = 0; i < 400; i++) begin
      int aw_r, ar_r;
      aw_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7);
      ar_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7);
      step($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, aw_r,
           $urandom_range(0, 255), $urandom_range(0, 2) != 0, ar_r,
           $urandom_range(0, 59) == 0);
    end
    idle(DEPTH + 2);
    for (int i = 0; i < 8; i++) rd(i);
    idle(2);
    chk("sb_empty", exp_q.size(), 0);

    begin
      int n;
      n = 0;
      b_reset = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (b_busy) n++;
        chk("sw_vld_idle", b_vld, 0);
        @(posedge clk); #1;
      end
      chk("sw_clr_len", n, 16);
      b_re = 1; b_ra = 4'd15; exp2_q.push_back(16'hBEEF);
      b_cycle_chk();
      b_re = 1; b_ra = 4'd0; b_we = 1; b_wa = 4'd0; b_wd = 16'h1234;
      exp2_q.push_back(16'h1234);
      b_cycle_chk();
      b_re = 0; b_we = 0;
      @(negedge clk);
      chk("sw_vld", b_vld, 1);
      if (b_vld && exp2_q.size() > 0) chk("sw_rd", b_dout, exp2_q.pop_front());
      @(posedge clk); #1;
      chk("sw_sb_empty", exp2_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter ADDR_WIDTH, default 6, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter CLEAR_VALUE, default 0, DATA_WIDTH-bit word written to every location by the clear engine.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 write_enable  input  1  write request for the current cycle.
REQ-007 write_address  input  ADDR_WIDTH  write location.
REQ-008 input_data  input  DATA_WIDTH  write data.
REQ-009 read_enable  input  1  read request for the current cycle.
REQ-010 read_address  input  ADDR_WIDTH  read location.
REQ-011 clear_request  input  1  single-cycle pulse that starts a full-memory clear.
REQ-012 output_data  output  DATA_WIDTH  registered read data.
REQ-013 output_valid  output  1  high for exactly one cycle when output_data carries the result of an accepted read.
REQ-014 busy  output  1  high while the clear engine runs; user reads and writes are not accepted.

Function
REQ-015 FSM has two states, CLEAR and READY; reset forces CLEAR with clear counter = 0.
REQ-016 In CLEAR, each cycle writes CLEAR_VALUE to location counter, then increments counter; after writing DEPTH-1, next state is READY, and the counter wraps to 0.
REQ-017 A full clear takes exactly DEPTH cycles; busy = 1 in every CLEAR cycle and 0 in READY.
REQ-018 In CLEAR, write_enable and read_enable are ignored: memory is not written from input_data, and output_valid stays 0.
REQ-019 In READY, clear_request = 1 moves the FSM to CLEAR with counter = 0 on the next edge; that cycle's user write and read are still accepted.
REQ-020 clear_request during CLEAR restarts the counter at 0; the clear then runs a further DEPTH cycles.
REQ-021 Write in READY: write_enable = 1 stores input_data at write_address at the rising edge.
REQ-022 Read in READY: read_enable = 1 samples read_address; output_data is updated on the same edge and output_valid = 1 for the following cycle, i.e. 1-cycle latency.
REQ-023 A same-cycle read and write to the same address in READY is write-first: output_data returns the new input_data.
REQ-024 A same-cycle read and write to different addresses are both performed with no interaction.
REQ-025 When no read is accepted, output_data holds its previous value and output_valid = 0.
REQ-026 Addresses are used modulo DEPTH (full ADDR_WIDTH range is valid); no out-of-range condition exists.
REQ-027 Back-to-back reads every cycle are supported with one result per cycle.

Reset
REQ-028 While reset = 1: output_data = 0, output_valid = 0, busy = 1, state = CLEAR, counter = 0, and no user write is performed.
REQ-029 Deasserting reset starts a full clear; the first user access is accepted DEPTH cycles after the first cycle with reset low.
REQ-030 reset asserted mid-clear or mid-operation restarts the clear from 0; memory contents written before that point are not guaranteed until the clear completes.

Verification
REQ-031 Reset, then wait: busy stays high for 64 cycles (defaults), then low; read address 34 -> output_data = 0x00, output_valid = 1 one cycle later.
REQ-032 Write 0x0A to address 3, next cycle read address 3 -> output_data = 0x0A with output_valid pulse; read address 63 -> 0x00.
REQ-033 Same cycle write 0x5C to address 17 and read address 17 -> output_data = 0x5C next cycle (write-first).
REQ-034 Write 0xFF to address 5, pulse clear_request, then attempt a write of 0x11 to address 6 during busy -> after 64 busy cycles, reads of addresses 5 and 6 both return 0x00.
REQ-035 Assert reset for 1 cycle at clear cycle 20 -> busy remains high a further 64 cycles after release; output_valid = 0 throughout.
REQ-036 Parameter sweep DATA_WIDTH = 16, ADDR_WIDTH = 4, CLEAR_VALUE = 0xBEEF -> clear lasts 16 cycles; read of address 15 returns 0xBEEF.
